waves_nios_nios2_qsys_0_oci_dct_packer: RTL and testbench

Producer side of the OCI debug-compressed-trace (DCT) path. It packs 2-bit trace atoms into a 30-bit `dct_buffer`, up to 15 atoms per word, tracked by a 4-bit `dct_count`. Full or flushed words go to a one-entry output register with a valid/ready handshake, which drives the DCT consumer and test-bench monitor inside the Nios II OCI.

---
 rtl/waves_nios_oci_dct_pkg.sv | 13 +
 rtl/waves_nios_oci_dct_outreg.sv | 39 +++
 rtl/waves_nios_nios2_qsys_0_oci_dct_packer.sv | 106 ++++++++++
 tb/tb_waves_nios_nios2_qsys_0_oci_dct_packer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/waves_nios_oci_dct_pkg.sv
// Shared types and widths for the OCI debug-compressed-trace (DCT) packer.
package waves_nios_oci_dct_pkg;
  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FULL  = 2'd1,
    FLUSH = 2'd2
  } dct_pk_state_t;

  localparam int DCT_ATOM_W = 2;
  localparam int DCT_BUF_W  = 30;
  localparam int DCT_CNT_W  = 4;
  localparam int DCT_DROP_W = 8;
endpackage

// File: rtl/waves_nios_oci_dct_outreg.sv
// One-entry valid/ready output register holding a packed DCT word and its atom count.
module waves_nios_oci_dct_outreg
  import waves_nios_oci_dct_pkg::*;
#(
  parameter int BW = DCT_BUF_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [BW-1:0]        data_i,
  input  logic [DCT_CNT_W-1:0] cnt_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [BW-1:0]        data_o,
  output logic [DCT_CNT_W-1:0] cnt_o
);
  logic                 valid_q;
  logic [BW-1:0]        data_q;
  logic [DCT_CNT_W-1:0] cnt_q;

  // Data holds its value after the handshake; only valid drops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      cnt_q   <= cnt_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/waves_nios_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace atoms into DCT words; OCI_DCT_DROP_CNT_EN adds a saturating drop counter.
module waves_nios_nios2_qsys_0_oci_dct_packer
  import waves_nios_oci_dct_pkg::*;
#(
  parameter int ATOMS_PER_WORD = 15
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               atom_valid,
  input  logic [DCT_ATOM_W-1:0]              atom,
  input  logic                               flush,
  input  logic                               out_ready,
  output logic                               word_valid,
  output logic [DCT_ATOM_W*ATOMS_PER_WORD-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0]               dct_count,
`ifdef OCI_DCT_DROP_CNT_EN
  output logic [DCT_DROP_W-1:0]              drop_cnt,
`endif
  output logic                               overflow,
  output logic                               drained
);
  localparam int BW = DCT_ATOM_W * ATOMS_PER_WORD;
  localparam logic [DCT_CNT_W-1:0] FULL_CNT = DCT_CNT_W'(ATOMS_PER_WORD);

  dct_pk_state_t        state_q;
  logic [BW-1:0]        acc_q, acc_d;
  logic [DCT_CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic                 free, xfer, accept, drop;

  assign free   = !word_valid || out_ready;
  assign xfer   = (state_q != ACCUM) && free && (acc_cnt_q != '0);
  // In a transfer cycle the atom always fits: it seeds the fresh accumulator.
  assign accept = atom_valid && (xfer || (acc_cnt_q < FULL_CNT));
  assign drop   = atom_valid && !accept;

  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    if (xfer) begin
      acc_d     = atom_valid ? BW'(atom) : '0;
      acc_cnt_d = {{(DCT_CNT_W-1){1'b0}}, atom_valid};
    end else if (accept) begin
      acc_d     = (acc_q << DCT_ATOM_W) | BW'(atom);
      acc_cnt_d = acc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      acc_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      if (xfer) begin
        state_q <= (acc_cnt_d == FULL_CNT) ? FULL : ACCUM;
      end else begin
        case (state_q)
          ACCUM: begin
            if (acc_cnt_d == FULL_CNT)            state_q <= FULL;
            else if (flush && acc_cnt_d != '0)    state_q <= FLUSH;
          end
          FULL:    state_q <= FULL;
          FLUSH:   state_q <= FLUSH;
          default: state_q <= ACCUM;
        endcase
      end
    end
  end

  waves_nios_oci_dct_outreg #(.BW(BW)) u_outreg (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (xfer),
    .data_i  (acc_q),
    .cnt_i   (acc_cnt_q),
    .ready_i (out_ready),
    .valid_o (word_valid),
    .data_o  (dct_buffer),
    .cnt_o   (dct_count)
  );

`ifdef OCI_DCT_DROP_CNT_EN
  logic [DCT_DROP_W-1:0] drop_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != '1)   drop_cnt_q <= drop_cnt_q + 1'b1;
  end

  assign drop_cnt = drop_cnt_q;
  assign overflow = (drop_cnt_q != '0);
`else
  logic overflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;
`endif

  assign drained = (state_q == ACCUM) && (acc_cnt_q == '0) && !word_valid;
endmodule

// File: tb/tb_waves_nios_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the DCT packer: packing, flush, stall/drop, streaming and async reset.
module tb_waves_nios_nios2_qsys_0_oci_dct_packer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom = 2'b00;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        word_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic        drained;
`ifdef OCI_DCT_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int words  = 0;

  always #5 clk = ~clk;

  waves_nios_nios2_qsys_0_oci_dct_packer dut (
    .clk        (clk),
    .reset      (reset),
    .atom_valid (atom_valid),
    .atom       (atom),
    .flush      (flush),
    .out_ready  (out_ready),
    .word_valid (word_valid),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
`ifdef OCI_DCT_DROP_CNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .overflow   (overflow),
    .drained    (drained)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    #1;
    check("rst_word_valid", {31'b0, word_valid}, 32'd0);
    check("rst_buffer",     {2'b0, dct_buffer},  32'd0);
    check("rst_count",      {28'b0, dct_count},  32'd0);
    check("rst_overflow",   {31'b0, overflow},   32'd0);
    check("rst_drained",    {31'b0, drained},    32'd1);
    do_reset();

    // 15 atoms of 01 -> one full word
    out_ready = 1'b1; atom_valid = 1'b1; atom = 2'b01;
    for (int i = 0; i < 15; i++) step();
    check("full_not_yet_valid", {31'b0, word_valid}, 32'd0);
    check("full_not_drained",   {31'b0, drained},    32'd0);
    atom_valid = 1'b0;
    step();
    check("full_valid",  {31'b0, word_valid}, 32'd1);
    check("full_buffer", {2'b0, dct_buffer},  32'h15555555);
    check("full_count",  {28'b0, dct_count},  32'd15);
    step();
    check("full_valid_drop", {31'b0, word_valid}, 32'd0);
    check("full_drained",    {31'b0, drained},    32'd1);

    // 3,2,1 then flush -> partial word 0x39
    atom_valid = 1'b1;
    atom = 2'b11; step();
    atom = 2'b10; step();
    atom = 2'b01; step();
    atom_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_latency", {31'b0, word_valid}, 32'd0);
    step();
    check("flush_valid",  {31'b0, word_valid}, 32'd1);
    check("flush_buffer", {2'b0, dct_buffer},  32'h39);
    check("flush_count",  {28'b0, dct_count},  32'd3);
    step();
    check("flush_one_cycle", {31'b0, word_valid}, 32'd0);

    // Flush on empty accumulator is ignored
    flush = 1'b1; step();
    flush = 1'b0; step();
    check("flush_empty_no_word", {31'b0, word_valid}, 32'd0);
    check("flush_empty_drained", {31'b0, drained},    32'd1);

    // Flush with a same-cycle atom on empty accumulator
    flush = 1'b1; atom_valid = 1'b1; atom = 2'b10;
    step();
    flush = 1'b0; atom_valid = 1'b0;
    step();
    check("flush_atom_valid",  {31'b0, word_valid}, 32'd1);
    check("flush_atom_buffer", {2'b0, dct_buffer},  32'h2);
    check("flush_atom_count",  {28'b0, dct_count},  32'd1);
    step();

    // Stall: out_ready low, 33 atoms; last three dropped
    out_ready = 1'b0; atom_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      atom = (i < 15) ? 2'b11 : 2'b10;
      step();
    end
    check("stall_no_overflow_yet", {31'b0, overflow}, 32'd0);
    for (int i = 0; i < 3; i++) step();
    atom_valid = 1'b0;
    step(); step();
    check("stall_valid",    {31'b0, word_valid}, 32'd1);
    check("stall_buffer",   {2'b0, dct_buffer},  32'h3FFFFFFF);
    check("stall_count",    {28'b0, dct_count},  32'd15);
    check("stall_overflow", {31'b0, overflow},   32'd1);
`ifdef OCI_DCT_DROP_CNT_EN
    check("stall_drop_cnt", {24'b0, drop_cnt},   32'd3);
`endif
    out_ready = 1'b1;
    step();
    check("stall_w2_valid",  {31'b0, word_valid}, 32'd1);
    check("stall_w2_buffer", {2'b0, dct_buffer},  32'h2AAAAAAA);
    check("stall_w2_count",  {28'b0, dct_count},  32'd15);
    step();
    check("stall_w2_gone",   {31'b0, word_valid}, 32'd0);
    check("stall_drained",   {31'b0, drained},    32'd1);

    // Streaming: 45 atoms back to back -> 3 full words
    do_reset();
    check("reset_clears_overflow", {31'b0, overflow}, 32'd0);
    out_ready = 1'b1; atom_valid = 1'b1; atom = 2'b01;
    for (int i = 0; i < 50; i++) begin
      if (i == 45) atom_valid = 1'b0;
      step();
      if (word_valid && dct_count == 4'd15 && dct_buffer == 30'h15555555) words++;
    end
    check("stream_words",    words,              32'd3);
    check("stream_overflow", {31'b0, overflow},  32'd0);
    check("stream_drained",  {31'b0, drained},   32'd1);

    // Async reset mid-accumulation
    atom_valid = 1'b1; atom = 2'b11;
    for (int i = 0; i < 7; i++) step();
    atom_valid = 1'b0;
    check("mid_not_drained", {31'b0, drained}, 32'd0);
    #1 reset = 1'b1;
    #1;
    check("async_acc_drained", {31'b0, drained}, 32'd1);
    reset = 1'b0;
    step();

    // Async reset while a word is held
    out_ready = 1'b0; atom_valid = 1'b1; atom = 2'b10;
    for (int i = 0; i < 15; i++) step();
    atom_valid = 1'b0;
    step();
    check("held_valid", {31'b0, word_valid}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_word_valid", {31'b0, word_valid}, 32'd0);
    check("async_buffer",     {2'b0, dct_buffer},  32'd0);
    check("async_count",      {28'b0, dct_count},  32'd0);
    check("async_overflow",   {31'b0, overflow},   32'd0);
    check("async_drained",    {31'b0, drained},    32'd1);
    reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
